// File: rtl/mem_arbiter.sv
// Shares one RAM port between the icache and dcache memory sides, one word at a time.
// Data requests win by default; a starvation counter forces an icache grant.
module mem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);
  localparam logic [1:0] RamAccess = 2'd2;

  typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            d_req;

  assign d_req = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= StIdle;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    iwait        = 1'b1;
    dwait        = 1'b1;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    unique case (state_q)
      StIdle: begin
        if (iREN && d_req) begin
          if (starve_cnt_q == Limit) begin
            state_d      = StGntI;
            starve_cnt_d = '0;
          end else begin
            // Counter is below Limit here, so the increment saturates at Limit.
            state_d      = StGntD;
            starve_cnt_d = starve_cnt_q + CntW'(1);
          end
        end else if (d_req) begin
          state_d      = StGntD;
          starve_cnt_d = '0;
        end else if (iREN) begin
          state_d      = StGntI;
          starve_cnt_d = '0;
        end
      end
      StGntI: begin
        if (!iREN) begin
          state_d = StIdle;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (ramstate == RamAccess) begin
            iwait   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      StGntD: begin
        if (!d_req) begin
          state_d = StIdle;
        end else begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (ramstate == RamAccess) begin
            dwait   = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, latency, write path, starvation, error retry, reset.
module tb_mem_arbiter;
  localparam logic [1:0] Free = 2'd0, Busy = 2'd1, Access = 2'd2, Error = 2'd3;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
  logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
  logic [1:0]  ramstate = Free;
  logic        iwait, dwait, ramREN, ramWEN;
  logic [31:0] iload, dload, ramaddr, ramstore;
  int          total = 0;
  int          bad = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  // Advance to just after the next rising edge; inputs for the new cycle are set after this.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #3;
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      bad++;
      $display("FAIL reset: waits/strobes=%b addr=%h store=%h, want 1100 0 0",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, ramstore);
    end
    tick();
    nRST = 1'b1;
  endtask

  task automatic test_ifetch();
    iREN = 1'b1; iaddr = 32'h40; ramstate = Free; ramload = 32'hDEADBEEF;
    #1;
    total++;
    if ({iwait, ramREN} !== 2'b10) begin
      bad++; $display("FAIL ifetch_idle: iwait,ramREN=%b want 10", {iwait, ramREN});
    end
    tick();
    ramstate = Access;
    #1;
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b0110 || ramaddr !== 32'h40 || iload !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL ifetch_grant: waits/strobes=%b addr=%h iload=%h want 0110 40 deadbeef",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, iload);
    end
    tick();
    iREN = 1'b0; ramstate = Free;
    #1;
    total++;
    if ({iwait, ramREN} !== 2'b10) begin
      bad++; $display("FAIL ifetch_done: iwait,ramREN=%b want 10", {iwait, ramREN});
    end
  endtask

  task automatic test_priority();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h200; ramstate = Access;
    ramload = 32'hCAFE0001;
    tick();
    #1;
    total++;
    if ({iwait, dwait, ramREN} !== 3'b101 || ramaddr !== 32'h200 || dload !== 32'hCAFE0001) begin
      bad++;
      $display("FAIL prio_dfirst: iwait,dwait,ramREN=%b addr=%h dload=%h want 101 200 cafe0001",
               {iwait, dwait, ramREN}, ramaddr, dload);
    end
    tick();
    dREN = 1'b0;
    #1;
    total++;
    if ({iwait, dwait, ramREN} !== 3'b110) begin
      bad++; $display("FAIL prio_bubble: iwait,dwait,ramREN=%b want 110", {iwait, dwait, ramREN});
    end
    tick();
    #1;
    total++;
    if ({iwait, dwait, ramREN} !== 3'b011 || ramaddr !== 32'h80) begin
      bad++;
      $display("FAIL prio_ithen: iwait,dwait,ramREN=%b addr=%h want 011 80",
               {iwait, dwait, ramREN}, ramaddr);
    end
    tick();
    iREN = 1'b0; ramstate = Free;
  endtask

  task automatic test_write();
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'h12345678; ramstate = Busy;
    for (int c = 1; c <= 4; c++) begin
      tick();
      ramstate = (c == 4) ? Access : Busy;
      #1;
      total++;
      if ({ramWEN, ramREN, dwait, iwait} !== {3'b10, (c != 4), 1'b1} ||
          ramaddr !== 32'h100 || ramstore !== 32'h12345678) begin
        bad++;
        $display("FAIL write_cyc%0d: wen,ren,dwait,iwait=%b addr=%h store=%h want %b 100 12345678",
                 c, {ramWEN, ramREN, dwait, iwait}, ramaddr, ramstore, {3'b10, (c != 4), 1'b1});
      end
    end
    tick();
    dWEN = 1'b0; ramstate = Free;
    #1;
    total++;
    if ({ramWEN, dwait} !== 2'b01 || ramstore !== 32'h0) begin
      bad++;
      $display("FAIL write_done: wen,dwait=%b store=%h want 01 0", {ramWEN, dwait}, ramstore);
    end
  endtask

  // Two rounds of four dcache grants then one forced icache grant; the second round
  // shows the counter restarted from zero.
  task automatic test_back_to_back();
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h300; ramstate = Access;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        tick();
        #1;
        total++;
        if ({iwait, dwait} !== 2'b10 || ramaddr !== 32'h300) begin
          bad++;
          $display("FAIL starve_r%0d_d%0d: iwait,dwait=%b addr=%h want 10 300",
                   r, k, {iwait, dwait}, ramaddr);
        end
        tick();
      end
      tick();
      #1;
      total++;
      if ({iwait, dwait} !== 2'b01 || ramaddr !== 32'h44) begin
        bad++;
        $display("FAIL starve_r%0d_i: iwait,dwait=%b addr=%h want 01 44", r, {iwait, dwait}, ramaddr);
      end
      tick();
    end
    iREN = 1'b0; dREN = 1'b0; ramstate = Free;
  endtask

  task automatic test_error();
    iREN = 1'b1; iaddr = 32'h48; ramstate = Error;
    for (int c = 1; c <= 3; c++) begin
      tick();
      dREN = 1'b1;
      ramstate = (c == 3) ? Access : Error;
      #1;
      total++;
      if ({iwait, dwait, ramREN, ramWEN} !== {(c != 3), 3'b110} || ramaddr !== 32'h48) begin
        bad++;
        $display("FAIL error_cyc%0d: waits/strobes=%b addr=%h want %b 48",
                 c, {iwait, dwait, ramREN, ramWEN}, ramaddr, {(c != 3), 3'b110});
      end
    end
    tick();
    iREN = 1'b0; dREN = 1'b0; ramstate = Free;
  endtask

  task automatic test_abort();
    dREN = 1'b1; daddr = 32'h500; ramstate = Busy;
    tick();
    #1;
    total++;
    if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h500) begin
      bad++; $display("FAIL abort_grant: ren,dwait=%b addr=%h want 11 500", {ramREN, dwait}, ramaddr);
    end
    #1;
    nRST = 1'b0;
    #1;
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      bad++;
      $display("FAIL abort_reset: waits/strobes=%b addr=%h store=%h want 1100 0 0",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, ramstore);
    end
    dREN = 1'b0; ramstate = Access;
    tick();
    nRST = 1'b1;
    tick();
    #1;
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100) begin
      bad++; $display("FAIL abort_idle: waits/strobes=%b want 1100", {iwait, dwait, ramREN, ramWEN});
    end
    // Withdrawal mid-grant.
    dREN = 1'b1; daddr = 32'h600; ramstate = Busy;
    tick();
    #1;
    total++;
    if ({ramREN, dwait} !== 2'b11 || ramaddr !== 32'h600) begin
      bad++; $display("FAIL withdraw_grant: ren,dwait=%b addr=%h want 11 600", {ramREN, dwait}, ramaddr);
    end
    tick();
    dREN = 1'b0; ramstate = Access;
    #1;
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 32'h0) begin
      bad++;
      $display("FAIL withdraw_cycle: waits/strobes=%b addr=%h want 1100 0",
               {iwait, dwait, ramREN, ramWEN}, ramaddr);
    end
    tick();
    #1;
    total++;
    if ({iwait, dwait, ramREN, ramWEN} !== 4'b1100 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
      bad++;
      $display("FAIL withdraw_idle: waits/strobes=%b addr=%h store=%h want 1100 0 0",
               {iwait, dwait, ramREN, ramWEN}, ramaddr, ramstore);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST && ((!iwait && !dwait) || (ramREN && ramWEN))) begin
      total++;
      bad++;
      $display("FAIL exclusivity: iwait=%b dwait=%b ramREN=%b ramWEN=%b want not both active",
               iwait, dwait, ramREN, ramWEN);
    end
  end

  initial begin
    test_reset();
    test_ifetch();
    test_priority();
    test_write();
    test_back_to_back();
    test_error();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
